// File: rtl/mem_pkg.sv
// Shared definitions for the dmem arbiter: window base, requester IDs, arbiter states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mem_pkg;

   localparam logic [31:0] DMEM_BASE = 32'h8000_0000;

   // Requester IDs double as bit positions in the 2-bit req/gnt vectors.
   localparam logic REQ_CORE = 1'b0;
   localparam logic REQ_DBG  = 1'b1;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a conflict the requester that was not granted last wins.
// Latency: purely combinational, no state.
// Backpressure: none; en = 0 suppresses every grant.
//
// Ports:
//   en    in  1  grant enable
//   req   in  2  requests, bit index = requester ID
//   last  in  1  ID of the most recent grant
//   gnt   out 2  one-hot (or zero) grant vector
module rr_arb2
   import mem_pkg::*;
(
   input  logic       en,
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         if (req == 2'b11) begin
            gnt = (last == REQ_DBG) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port dmem between core (C) and debug/loader (D) ports; round-robin with debug lock.
// Latency: grant combinational in the request cycle; response (rvalid/rdata/err) one cycle later.
// Backpressure: requester holds req until gnt; one grant per cycle, locked debug blocks the core.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_be/c_wdata   core request;   c_gnt, c_rvalid, c_rdata, c_err responses
//   d_req/d_we/d_addr/d_be/d_wdata   debug request;  d_gnt, d_rvalid, d_rdata, d_err responses
//   d_lock                           debug asks to keep the grant across back-to-back accesses
//   mem_en/we/be/addr/wdata, mem_rdata  dmem port, read data valid the cycle after mem_en
module dmem_arbiter
   import mem_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE = mem_pkg::DMEM_BASE,
   parameter int          ADDR_W    = 8,
   parameter int          LOCK_MAX  = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [31:0]       c_addr,
   input  logic [3:0]        c_be,
   input  logic [31:0]       c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [31:0]       c_rdata,
   output logic              c_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [31:0]       d_addr,
   input  logic [3:0]        d_be,
   input  logic [31:0]       d_wdata,
   input  logic              d_lock,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam int          CNT_W     = $clog2(LOCK_MAX + 1);
   localparam logic [32:0] WIN_BYTES = 33'(4) << ADDR_W;

   arb_state_t       state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
   logic             lock_blk_q, lock_blk_d;
   logic             resp_vld_q, resp_own_q, resp_err_q, resp_rd_q;

   logic [1:0]  arb_req, arb_gnt;
   logic        any_gnt, sel_dbg, sel_we, in_range;
   logic [31:0] sel_addr, sel_wdata, offset;
   logic [3:0]  sel_be;

   // While locked the core request is masked, so the picker sees debug alone.
   assign arb_req = {d_req, c_req & (state_q == ARB)};

   rr_arb2 u_rr (
      .en   (!rst),
      .req  (arb_req),
      .last (last_q),
      .gnt  (arb_gnt)
   );

   assign c_gnt   = arb_gnt[REQ_CORE];
   assign d_gnt   = arb_gnt[REQ_DBG];
   assign any_gnt = |arb_gnt;
   assign sel_dbg = arb_gnt[REQ_DBG];

   assign sel_we    = sel_dbg ? d_we    : c_we;
   assign sel_addr  = sel_dbg ? d_addr  : c_addr;
   assign sel_be    = sel_dbg ? d_be    : c_be;
   assign sel_wdata = sel_dbg ? d_wdata : c_wdata;

   // Unsigned wrap makes addresses below the base land far above the window.
   assign offset   = sel_addr - DMEM_BASE;
   assign in_range = {1'b0, offset} < WIN_BYTES;

   assign mem_en    = any_gnt & in_range;
   assign mem_we    = mem_en & sel_we;
   assign mem_be    = sel_be;
   assign mem_addr  = offset[ADDR_W+1:2];
   assign mem_wdata = sel_wdata;

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      lock_cnt_d = lock_cnt_q;
      lock_blk_d = lock_blk_q;
      if (any_gnt) begin
         last_d = sel_dbg;
      end
      case (state_q)
         ARB: begin
            if (d_gnt && d_lock && !lock_blk_q) begin
               if (LOCK_MAX <= 1) begin
                  lock_blk_d = 1'b1;   // a single grant already exhausts the lock
               end else begin
                  state_d    = LOCKED;
                  lock_cnt_d = CNT_W'(1);
               end
            end
         end
         LOCKED: begin
            if (!d_lock) begin
               state_d    = ARB;
               lock_cnt_d = '0;
            end else if (d_gnt) begin
               if (lock_cnt_q + CNT_W'(1) == CNT_W'(LOCK_MAX)) begin
                  // Timeout: force release and hand the next conflict to the core.
                  state_d    = ARB;
                  lock_cnt_d = '0;
                  lock_blk_d = 1'b1;
                  last_d     = REQ_DBG;
               end else begin
                  lock_cnt_d = lock_cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = ARB;
      endcase
      if (!d_lock) begin
         lock_blk_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ARB;
         last_q     <= REQ_DBG;
         lock_cnt_q <= '0;
         lock_blk_q <= 1'b0;
         resp_vld_q <= 1'b0;
         resp_own_q <= REQ_CORE;
         resp_err_q <= 1'b0;
         resp_rd_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
         lock_blk_q <= lock_blk_d;
         resp_vld_q <= any_gnt;
         resp_own_q <= sel_dbg;
         resp_err_q <= !in_range;
         resp_rd_q  <= in_range & !sel_we;
      end
   end

   // Reset masks the response combinationally so an in-flight read is dropped at once.
   assign c_rvalid = resp_vld_q && (resp_own_q == REQ_CORE) && !rst;
   assign d_rvalid = resp_vld_q && (resp_own_q == REQ_DBG) && !rst;
   assign c_rdata  = (c_rvalid && resp_rd_q) ? mem_rdata : 32'h0;
   assign d_rdata  = (d_rvalid && resp_rd_q) ? mem_rdata : 32'h0;
   assign c_err    = c_rvalid && resp_err_q;
   assign d_err    = d_rvalid && resp_err_q;

endmodule
